// File: rtl/input_unit_fsm.sv
// input_unit_fsm: router input port with flit FIFO, XY routing and switch request.
// Optional macro INPUT_UNIT_PKT_CNT_EN adds o_pkt_cnt (tail flits forwarded).

package noc_pkg;
    localparam int NUM_OF_PORTS = 5;
    localparam int PORT_W = $clog2(NUM_OF_PORTS);
    localparam int FLIT_COORD_W = 4;
    localparam int FLIT_DATA_W = 16;

    localparam logic [PORT_W-1:0] PORT_LOCAL = PORT_W'(0);
    localparam logic [PORT_W-1:0] PORT_NORTH = PORT_W'(1);
    localparam logic [PORT_W-1:0] PORT_EAST  = PORT_W'(2);
    localparam logic [PORT_W-1:0] PORT_SOUTH = PORT_W'(3);
    localparam logic [PORT_W-1:0] PORT_WEST  = PORT_W'(4);

    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } FLIT_TYPE_t;

    typedef struct packed {
        logic                      valid;
        FLIT_TYPE_t                flit_type;
        logic [FLIT_COORD_W-1:0]   dst_x;
        logic [FLIT_COORD_W-1:0]   dst_y;
        logic [FLIT_DATA_W-2*FLIT_COORD_W-1:0] data;
    } HEAD_t;

    typedef struct packed {
        logic                   valid;
        FLIT_TYPE_t             flit_type;
        logic [FLIT_DATA_W-1:0] data;
    } TAIL_t;

    typedef union packed {
        HEAD_t head;
        TAIL_t tail;
    } FLIT_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTING = 2'd1,
        WAITING = 2'd2,
        ACTIVE  = 2'd3
    } GLOBAL_STATE_t;
endpackage

module input_unit_fsm
    import noc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int COORD_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [COORD_W-1:0]      i_router_x,
    input  logic [COORD_W-1:0]      i_router_y,
    input  FLIT_t                   i_flit,
    output logic                    o_ready,
    output logic [NUM_OF_PORTS-1:0] o_switch_req,
    input  logic [NUM_OF_PORTS-1:0] i_outport_ack,
    output FLIT_t                   o_flit,
    output GLOBAL_STATE_t           o_gstate,
    output logic [PORT_W-1:0]       o_route
`ifdef INPUT_UNIT_PKT_CNT_EN
    ,
    output logic [15:0]             o_pkt_cnt
`endif
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    FLIT_t               mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    FLIT_t               head;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                is_head;
    logic                is_tail;
    logic                drop;
    logic                send;
    GLOBAL_STATE_t       state;
    logic [PORT_W-1:0]   route;
    logic [PORT_W-1:0]   route_next;
    logic [COORD_W-1:0]  dst_x;
    logic [COORD_W-1:0]  dst_y;

    assign head    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(BUF_DEPTH));
    assign push    = i_flit.tail.valid && !full;
    assign is_head = (head.tail.flit_type == HEAD_FLIT);
    assign is_tail = (head.tail.flit_type == TAIL_FLIT);
    assign drop    = (state == IDLE) && !empty && !is_head;
    assign send    = (state == ACTIVE) && !empty;
    assign pop     = drop || send;
    assign dst_x   = COORD_W'(head.head.dst_x);
    assign dst_y   = COORD_W'(head.head.dst_y);

    // Flit storage; a slot is only read after its push has landed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_flit;
    end

    // FIFO pointers and occupancy; reset flushes anything buffered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Dimension-order XY route: X is resolved before Y, ties go local.
    always_comb begin
        route_next = PORT_LOCAL;
        if (dst_x > i_router_x)      route_next = PORT_EAST;
        else if (dst_x < i_router_x) route_next = PORT_WEST;
        else if (dst_y > i_router_y) route_next = PORT_NORTH;
        else if (dst_y < i_router_y) route_next = PORT_SOUTH;
    end

    // Packet FSM: wait for a head, route it, win the output, stream to tail.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            route <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty && is_head) state <= ROUTING;
                end
                ROUTING: begin
                    route <= route_next;
                    state <= WAITING;
                end
                WAITING: begin
                    if (i_outport_ack[route]) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (send && is_tail) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INPUT_UNIT_PKT_CNT_EN
    logic [15:0] pkt_cnt;

    // Count packets whose tail has left toward the crossbar.
    always_ff @(posedge clk) begin
        if (!reset_n)            pkt_cnt <= '0;
        else if (send && is_tail) pkt_cnt <= pkt_cnt + 1'b1;
    end

    assign o_pkt_cnt = pkt_cnt;
`endif

`ifndef SYNTHESIS
    // A body/tail at the head in IDLE has lost its head flit upstream.
    always_ff @(posedge clk) begin
        if (reset_n && drop) $error("input_unit_fsm: discarded stray non-head flit");
    end
`endif

    assign o_ready      = !full;
    assign o_switch_req = (state == WAITING) ?
                          (NUM_OF_PORTS'(1) << route) : '0;
    assign o_flit       = send ? head : '0;
    assign o_gstate     = state;
    assign o_route      = route;

endmodule

// File: tb/tb_input_unit_fsm.sv
// tb_input_unit_fsm: directed and randomized checks of input_unit_fsm
// against a queue-based packet model.

module tb_input_unit_fsm;
    import noc_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    rx = 4'd2;
    logic [3:0]    ry = 4'd2;
    FLIT_t         i_flit = '0;
    logic          o_ready;
    logic [4:0]    o_switch_req;
    logic [4:0]    i_outport_ack = '0;
    FLIT_t         o_flit;
    GLOBAL_STATE_t o_gstate;
    logic [2:0]    o_route;
`ifdef INPUT_UNIT_PKT_CNT_EN
    logic [15:0]   o_pkt_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          n_deliv = 0;
    logic [15:0] exp_cnt = '0;
    bit          ack_en = 1'b0;
    bit          noise_en = 1'b0;
    bit          gap_en = 1'b0;
    FLIT_t       pend[$];
    FLIT_t       acc_q[$];

    input_unit_fsm #(.BUF_DEPTH(DEPTH), .COORD_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_router_x   (rx),
        .i_router_y   (ry),
        .i_flit       (i_flit),
        .o_ready      (o_ready),
        .o_switch_req (o_switch_req),
        .i_outport_ack(i_outport_ack),
        .o_flit       (o_flit),
        .o_gstate     (o_gstate),
        .o_route      (o_route)
`ifdef INPUT_UNIT_PKT_CNT_EN
        ,
        .o_pkt_cnt    (o_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_port(input logic [3:0] x, y,
                                            input logic [3:0] dx, dy);
        if (dx > x) return 3'd2;
        if (dx < x) return 3'd4;
        if (dy > y) return 3'd1;
        if (dy < y) return 3'd3;
        return 3'd0;
    endfunction

    function automatic FLIT_t mk_head(input logic [3:0] dx, dy,
                                      input logic [7:0] d);
        FLIT_t f;
        f = '0;
        f.head.valid = 1'b1;
        f.head.flit_type = HEAD_FLIT;
        f.head.dst_x = dx;
        f.head.dst_y = dy;
        f.head.data = d;
        return f;
    endfunction

    function automatic FLIT_t mk_flit(input FLIT_TYPE_t t,
                                      input logic [15:0] d);
        FLIT_t f;
        f = '0;
        f.tail.valid = 1'b1;
        f.tail.flit_type = t;
        f.tail.data = d;
        return f;
    endfunction

    // One clock: drive upstream/ack, check outputs against the model, advance.
    task automatic tick();
        logic [4:0] oh;
        logic [2:0] er;
        logic       ready_exp;
        FLIT_t      ef;
        oh = '0;
        er = '0;
        if (pend.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0))
            i_flit = pend[0];
        else
            i_flit = '0;
        if (acc_q.size() > 0 && acc_q[0].tail.flit_type == HEAD_FLIT) begin
            er = exp_port(rx, ry, acc_q[0].head.dst_x, acc_q[0].head.dst_y);
            oh = 5'b00001 << er;
        end
        i_outport_ack = (ack_en ? oh : 5'b0) |
                        (noise_en ? (5'($urandom) & ~oh) : 5'b0);
        ready_exp = (acc_q.size() < DEPTH);
        check("o_ready", 64'(o_ready), 64'(ready_exp));
        if (o_gstate == WAITING) begin
            check("switch_req", 64'(o_switch_req), 64'(oh));
            if (oh != 5'b0) check("route", 64'(o_route), 64'(er));
        end
        if (o_flit.tail.valid) begin
            if (acc_q.size() == 0) begin
                check("o_flit_spurious", 64'(o_flit), 64'd0);
            end else begin
                ef = acc_q.pop_front();
                check("o_flit", 64'(o_flit), 64'(ef));
                n_deliv++;
                if (ef.tail.flit_type == TAIL_FLIT) exp_cnt++;
            end
        end else begin
            check("o_flit_idle", 64'(o_flit), 64'd0);
        end
        if (reset_n && i_flit.tail.valid && ready_exp) begin
            acc_q.push_back(i_flit);
            void'(pend.pop_front());
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            acc_q.delete();
            exp_cnt = '0;
        end
    endtask

    task automatic wait_state(input GLOBAL_STATE_t s, input int budget,
                              input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (o_gstate != s && n < budget);
        check(tag, 64'(o_gstate), 64'(s));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((pend.size() != 0 || acc_q.size() != 0 ||
                    o_gstate != IDLE) && n < budget);
        check({tag, "_drain"}, 64'(pend.size() + acc_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(o_gstate), 64'(IDLE));
    endtask

    task automatic load_pkt(input logic [3:0] dx, dy, input int nbody);
        pend.push_back(mk_head(dx, dy, 8'($urandom)));
        for (int b = 0; b < nbody; b++)
            pend.push_back(mk_flit(BODY_FLIT, 16'($urandom)));
        pend.push_back(mk_flit(TAIL_FLIT, 16'($urandom)));
    endtask

    initial begin
        int          dxs[4] = '{1, 2, 2, 2};
        int          dys[4] = '{2, 3, 1, 2};
        int          idx[4] = '{4, 1, 3, 0};
        FLIT_t       h, b, t;
        int          d0;
        logic [3:0]  dx, dy;

        // Reset
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_state", 64'(o_gstate), 64'(IDLE));
        check("rst_route", 64'(o_route), 64'd0);
        check("rst_req", 64'(o_switch_req), 64'd0);
        check("rst_flit", 64'(o_flit), 64'd0);
`ifdef INPUT_UNIT_PKT_CNT_EN
        check("rst_cnt", 64'(o_pkt_cnt), 64'd0);
`endif

        // Latency: 3-flit packet east, ack on first request cycle
        ack_en = 1'b1;
        h = mk_head(4'd3, 4'd2, 8'hA5);
        b = mk_flit(BODY_FLIT, 16'h1234);
        t = mk_flit(TAIL_FLIT, 16'hBEEF);
        pend.push_back(h);
        pend.push_back(b);
        pend.push_back(t);
        tick();
        check("lat_c0_idle", 64'(o_gstate), 64'(IDLE));
        tick();
        check("lat_c1_routing", 64'(o_gstate), 64'(ROUTING));
        tick();
        check("lat_c2_waiting", 64'(o_gstate), 64'(WAITING));
        check("lat_c2_req", 64'(o_switch_req), 64'(5'b00100));
        check("lat_c2_route", 64'(o_route), 64'd2);
        tick();
        check("lat_c3_active", 64'(o_gstate), 64'(ACTIVE));
        check("lat_c3_head", 64'(o_flit), 64'(h));
        check("lat_c3_req0", 64'(o_switch_req), 64'd0);
        tick();
        check("lat_c4_body", 64'(o_flit), 64'(b));
        tick();
        check("lat_c5_tail", 64'(o_flit), 64'(t));
        tick();
        check("lat_c6_idle", 64'(o_gstate), 64'(IDLE));
        check("lat_c6_flit0", 64'(o_flit), 64'd0);
`ifdef INPUT_UNIT_PKT_CNT_EN
        check("lat_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
`endif

        // Route coverage with non-matching ack noise while waiting
        noise_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack_en = 1'b0;
            load_pkt(4'(dxs[i]), 4'(dys[i]), 0);
            wait_state(WAITING, 10, "rc_wait");
            repeat (3) tick();
            check("rc_hold", 64'(o_gstate), 64'(WAITING));
            check("rc_route", 64'(o_route), 64'(idx[i]));
            check("rc_req", 64'(o_switch_req), 64'(5'b00001 << idx[i]));
            ack_en = 1'b1;
            wait_drain(20, "rc");
        end

        // Backpressure: 6 flits, ack held low for 10 cycles
        ack_en = 1'b0;
        d0 = n_deliv;
        load_pkt(4'd3, 4'd2, 4);
        repeat (10) tick();
        check("bp_ready0", 64'(o_ready), 64'd0);
        check("bp_waiting", 64'(o_gstate), 64'(WAITING));
        check("bp_held", 64'(pend.size()), 64'd2);
        ack_en = 1'b1;
        wait_drain(30, "bp");
        check("bp_count", 64'(n_deliv - d0), 64'd6);

        // Bubble in ACTIVE
        noise_en = 1'b0;
        h = mk_head(4'd2, 4'd3, 8'h3C);
        b = mk_flit(BODY_FLIT, 16'h5A5A);
        t = mk_flit(TAIL_FLIT, 16'hC0DE);
        pend.push_back(h);
        pend.push_back(b);
        wait_state(ACTIVE, 10, "bub_active");
        check("bub_head", 64'(o_flit), 64'(h));
        tick();
        check("bub_body", 64'(o_flit), 64'(b));
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bub_gap", 64'(o_flit), 64'd0);
            check("bub_stay", 64'(o_gstate), 64'(ACTIVE));
            if (i == 2) pend.push_back(t);
            tick();
        end
        check("bub_tail", 64'(o_flit), 64'(t));
        tick();
        check("bub_idle", 64'(o_gstate), 64'(IDLE));

        // Reset one cycle after the head is forwarded
        load_pkt(4'd0, 4'd2, 2);
        wait_state(ACTIVE, 10, "mr_active");
        tick();
        reset_n = 1'b0;
        pend.delete();
        tick();
        reset_n = 1'b1;
        check("mr_idle", 64'(o_gstate), 64'(IDLE));
        check("mr_ready", 64'(o_ready), 64'd1);
        check("mr_flit", 64'(o_flit), 64'd0);
        check("mr_req", 64'(o_switch_req), 64'd0);
        check("mr_route", 64'(o_route), 64'd0);
`ifdef INPUT_UNIT_PKT_CNT_EN
        check("mr_cnt", 64'(o_pkt_cnt), 64'd0);
`endif
        wait_drain(5, "mr");

        // Randomized packets, gaps and ack noise
        gap_en = 1'b1;
        noise_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            for (int p = 0; p < 1 + (it % 2); p++) begin
                dx = ($urandom_range(0, 2) == 0) ? rx : 4'($urandom);
                dy = ($urandom_range(0, 2) == 0) ? ry : 4'($urandom);
                load_pkt(dx, dy, $urandom_range(0, 3));
            end
            wait_drain(300, "rnd");
`ifdef INPUT_UNIT_PKT_CNT_EN
            check("rnd_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
`endif
        end
        gap_en = 1'b0;
        noise_en = 1'b0;

`ifdef INPUT_UNIT_PKT_CNT_EN
        // Counter wrap from 16'hFFFE
        force dut.pkt_cnt = 16'hFFFE;
        #1;
        release dut.pkt_cnt;
        exp_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            load_pkt(4'd2, 4'd2, 0);
            wait_drain(20, "wrap");
            check("wrap_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        end
        check("wrap_final", 64'(o_pkt_cnt), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
